output_port_ctrl: RTL and testbench
===================================

Name: output_port_ctrl

Overview:
- Output-port controller for one router output, e.g. the link to a neighbour.
- Accepts the flit granted by the output arbiter from one of five input buffers (pe, s, n, e, w) and stores it in a two-entry virtual-channel (VC) buffer, one entry per VC (even/odd).
- Forwards stored flits to the downstream link under a ready handshake.
- A global polarity bit alternates which VC is written internally and which VC is driven on the link.

Parameters:
- DATA_WIDTH, 64, flit width in bits.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- polarity  input  1  global phase: 0 = even VC internal / odd VC on link; 1 = odd VC internal / even VC on link.
- grant  input  5  one-hot grant from the output arbiter; bit0=pe, bit1=s, bit2=n, bit3=e, bit4=w.
- data_in_pe, data_in_s, data_in_n, data_in_e, data_in_w  input  64 each  head flit of each input buffer.
- receive_output  input  1  downstream ready: the downstream router can accept a flit this cycle.
- data_out  output  64  flit driven on the link.
- empty  output  1  the internal-side VC buffer can accept a flit this cycle.
- send_output  output  1  data_out is valid and is being transferred this cycle.
- clear_pe, clear_s, clear_n, clear_e, clear_w  output  1 each  pop strobe to the matching input buffer.

Behaviour:
- Storage: two 64-bit registers buf[0] (even VC) and buf[1] (odd VC), each with a full flag.
- Reset (async, reset=1): both full flags = 0 and both registers = 0. Outputs during reset: send_output=0, data_out=0, all clear_*=0, empty=1.
- Internal side is index ip = polarity. Link side is index lp = ~polarity. The two sides never address the same buffer in one cycle, so simultaneous write and send need no arbitration.
- empty = ~full[ip], combinational.
- Grant is valid only when it has exactly one bit set. A zero or multi-bit grant is ignored: no write, all clear_* = 0.
- Accept, when grant is valid and full[ip]=0:
  - the matching clear_x = 1 in the same cycle (combinational);
  - at the next rising edge, buf[ip] <= selected data_in_x and full[ip] <= 1.
- Grant while full[ip]=1: ignored, no clear, buffer contents unchanged.
- Send, when full[lp]=1 and receive_output=1:
  - send_output=1 and data_out=buf[lp] (combinational);
  - at the next rising edge, full[lp] <= 0.
- No send (full[lp]=0 or receive_output=0): send_output=0, data_out=0. The buffer holds its flit until a later link-side phase with receive_output=1.
- Latency: a flit accepted in a cycle with polarity p is sent in the following cycle (polarity ~p) if receive_output=1. Accept-to-send is therefore 1 cycle.
- At most one clear_* is high in any cycle.
- Reset asserted mid-operation discards both stored flits immediately.

Test Plan:
- Reset: assert reset, check send_output=0, data_out=0, empty=1, all clear_*=0. Release with polarity=0 at a clock edge.
- Sequential accept/forward:
  - Setup: data_in_pe..w = AAAA.., BBBB.., CCCC.., DDDD.., EEEE.. (64-bit replicated patterns). receive_output=1, polarity toggling every cycle, grant = 00001, 00010, 00100, 01000, 10000 on successive cycles.
  - Expected: each cycle raises the matching clear_x. Starting one cycle later, data_out = AAAA.., BBBB.., CCCC.., DDDD.., EEEE.. in order with send_output=1.
- Backpressure:
  - Stimulus: receive_output=0 with grant=10000 held.
  - Expected: send_output=0 and data_out=0. After both VCs fill, empty=0 and clear_w=0.
  - Then receive_output=1: the stored EEEE.. flits drain one per cycle, and empty returns to 1.
- New data: change inputs to 1111.., 2222.., 3333.., 4444.., 5555..; grant pe then s with receive_output=1 → data_out = 1111.. then 2222...
- No/invalid grant: grant=00000 and grant=00011 → no clear_*, empty stays 1, and no send occurs on the following cycle.
- Reset mid-flight: assert reset while a VC is full → send_output drops to 0 immediately and empty=1 after release.

Source files
------------

// File: rtl/output_port_ctrl_if.sv
// rtl/output_port_ctrl_if.sv - arbiter-side and link-side signals of one router output port
// The master drives grants, head flits and downstream ready; the slave is the port controller.
interface output_port_ctrl_if #(
  parameter int DATA_WIDTH = 64
);
  logic [4:0]            grant;
  logic [DATA_WIDTH-1:0] data_in_pe;
  logic [DATA_WIDTH-1:0] data_in_s;
  logic [DATA_WIDTH-1:0] data_in_n;
  logic [DATA_WIDTH-1:0] data_in_e;
  logic [DATA_WIDTH-1:0] data_in_w;
  logic                  receive_output;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  send_output;
  logic                  clear_pe;
  logic                  clear_s;
  logic                  clear_n;
  logic                  clear_e;
  logic                  clear_w;

  modport master (
    output grant, data_in_pe, data_in_s, data_in_n, data_in_e, data_in_w, receive_output,
    input  data_out, empty, send_output, clear_pe, clear_s, clear_n, clear_e, clear_w
  );

  modport slave (
    input  grant, data_in_pe, data_in_s, data_in_n, data_in_e, data_in_w, receive_output,
    output data_out, empty, send_output, clear_pe, clear_s, clear_n, clear_e, clear_w
  );
endinterface

// File: rtl/output_port_ctrl.sv
// rtl/output_port_ctrl.sv - two-VC output port: arbiter-granted flit in, link flit out
// Polarity selects the internal-side VC; the link side is always the other one.
module output_port_ctrl #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 polarity,
  output_port_ctrl_if.slave    port
);

  logic [1:0][DATA_WIDTH-1:0] vc_buf_q, vc_buf_d;
  logic [1:0]                 full_q, full_d;

  logic                  ip, lp;
  logic                  grant_valid;
  logic                  accept;
  logic                  send;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    ip          = polarity;
    lp          = ~polarity;
    grant_valid = (port.grant != 5'd0) && ((port.grant & (port.grant - 5'd1)) == 5'd0);
    // Clears are gated by reset so no input buffer pops while the port is held in reset.
    accept      = grant_valid && !full_q[ip] && !reset;
    send        = full_q[lp] && port.receive_output;

    sel_data = '0;
    case (port.grant)
      5'b00001: sel_data = port.data_in_pe;
      5'b00010: sel_data = port.data_in_s;
      5'b00100: sel_data = port.data_in_n;
      5'b01000: sel_data = port.data_in_e;
      5'b10000: sel_data = port.data_in_w;
      default:  sel_data = '0;
    endcase

    vc_buf_d = vc_buf_q;
    full_d   = full_q;
    if (accept) begin
      vc_buf_d[ip] = sel_data;
      full_d[ip]   = 1'b1;
    end
    if (send) begin
      full_d[lp] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vc_buf_q <= '0;
      full_q   <= '0;
    end else begin
      vc_buf_q <= vc_buf_d;
      full_q   <= full_d;
    end
  end

  assign port.empty       = ~full_q[ip];
  assign port.send_output = send;
  assign port.data_out    = send ? vc_buf_q[lp] : '0;
  assign port.clear_pe    = accept && port.grant[0];
  assign port.clear_s     = accept && port.grant[1];
  assign port.clear_n     = accept && port.grant[2];
  assign port.clear_e     = accept && port.grant[3];
  assign port.clear_w     = accept && port.grant[4];

endmodule

// File: tb/tb_output_port_ctrl.sv
// tb/tb_output_port_ctrl.sv - directed bench for output_port_ctrl
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
module tb_output_port_ctrl;

  logic clk;
  logic reset;
  logic polarity;
  int   checks;
  int   errors;

  output_port_ctrl_if #(.DATA_WIDTH(64)) port_if ();

  output_port_ctrl #(.DATA_WIDTH(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .port     (port_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] clears();
    return {port_if.clear_w, port_if.clear_e, port_if.clear_n, port_if.clear_s, port_if.clear_pe};
  endfunction

  task automatic drive(input logic pol, input logic [4:0] g, input logic rcv);
    polarity               = pol;
    port_if.grant          = g;
    port_if.receive_output = rcv;
    #3;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                            input logic [63:0] d, input logic [63:0] e);
    port_if.data_in_pe = a;
    port_if.data_in_s  = b;
    port_if.data_in_n  = c;
    port_if.data_in_e  = d;
    port_if.data_in_w  = e;
  endtask

  logic [63:0] pat [5];

  initial begin
    checks = 0;
    errors = 0;
    pat[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    pat[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    pat[2] = 64'hCCCC_CCCC_CCCC_CCCC;
    pat[3] = 64'hDDDD_DDDD_DDDD_DDDD;
    pat[4] = 64'hEEEE_EEEE_EEEE_EEEE;
    set_inputs(pat[0], pat[1], pat[2], pat[3], pat[4]);

    // Reset with a valid grant present: nothing may pop.
    reset = 1'b1;
    drive(1'b0, 5'b00001, 1'b1);
    check_val("rst_send", {63'd0, port_if.send_output}, 64'd1 - 64'd1);
    check_val("rst_data", port_if.data_out, 64'd0);
    check_val("rst_empty", {63'd0, port_if.empty}, 64'd1);
    check_val("rst_clear", {59'd0, clears()}, 64'd0);
    next_cycle();
    reset = 1'b0;

    // Sequential accept/forward, polarity toggling.
    for (int k = 0; k < 6; k++) begin
      drive(k[0], (k < 5) ? (5'b00001 << k) : 5'b00000, 1'b1);
      check_val($sformatf("seq_clear%0d", k), {59'd0, clears()},
                (k < 5) ? (64'd1 << k) : 64'd0);
      check_val($sformatf("seq_send%0d", k), {63'd0, port_if.send_output}, (k >= 1) ? 64'd1 : 64'd0);
      check_val($sformatf("seq_data%0d", k), port_if.data_out, (k >= 1) ? pat[k-1] : 64'd0);
      next_cycle();
    end

    // Backpressure: both VCs fill with EEEE, then the grant is refused.
    drive(1'b0, 5'b10000, 1'b0);
    check_val("bp_clear6", {59'd0, clears()}, 64'h10);
    check_val("bp_send6", {63'd0, port_if.send_output}, 64'd0);
    next_cycle();
    drive(1'b1, 5'b10000, 1'b0);
    check_val("bp_clear7", {59'd0, clears()}, 64'h10);
    check_val("bp_data7", port_if.data_out, 64'd0);
    next_cycle();
    drive(1'b0, 5'b10000, 1'b0);
    check_val("bp_empty8", {63'd0, port_if.empty}, 64'd0);
    check_val("bp_clear8", {59'd0, clears()}, 64'd0);
    check_val("bp_send8", {63'd0, port_if.send_output}, 64'd0);
    next_cycle();
    drive(1'b1, 5'b00000, 1'b1);
    check_val("drain_send9", {63'd0, port_if.send_output}, 64'd1);
    check_val("drain_data9", port_if.data_out, pat[4]);
    check_val("drain_empty9", {63'd0, port_if.empty}, 64'd0);
    next_cycle();
    drive(1'b0, 5'b00000, 1'b1);
    check_val("drain_data10", port_if.data_out, pat[4]);
    check_val("drain_empty10", {63'd0, port_if.empty}, 64'd1);
    next_cycle();
    drive(1'b1, 5'b00000, 1'b1);
    check_val("drain_send11", {63'd0, port_if.send_output}, 64'd0);
    check_val("drain_empty11", {63'd0, port_if.empty}, 64'd1);
    next_cycle();

    // New data.
    set_inputs(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333,
               64'h4444_4444_4444_4444, 64'h5555_5555_5555_5555);
    drive(1'b0, 5'b00001, 1'b1);
    check_val("new_clear12", {59'd0, clears()}, 64'h01);
    next_cycle();
    drive(1'b1, 5'b00010, 1'b1);
    check_val("new_clear13", {59'd0, clears()}, 64'h02);
    check_val("new_data13", port_if.data_out, 64'h1111_1111_1111_1111);
    next_cycle();
    drive(1'b0, 5'b00000, 1'b1);
    check_val("new_data14", port_if.data_out, 64'h2222_2222_2222_2222);
    next_cycle();

    // No grant and multi-bit grant.
    drive(1'b1, 5'b00000, 1'b1);
    check_val("nog_clear15", {59'd0, clears()}, 64'd0);
    check_val("nog_empty15", {63'd0, port_if.empty}, 64'd1);
    check_val("nog_send15", {63'd0, port_if.send_output}, 64'd0);
    next_cycle();
    drive(1'b0, 5'b00011, 1'b1);
    check_val("inv_clear16", {59'd0, clears()}, 64'd0);
    check_val("inv_empty16", {63'd0, port_if.empty}, 64'd1);
    next_cycle();
    drive(1'b1, 5'b00000, 1'b1);
    check_val("inv_send17", {63'd0, port_if.send_output}, 64'd0);
    check_val("inv_data17", port_if.data_out, 64'd0);
    next_cycle();

    // Reset mid-flight with VC0 holding a flit.
    drive(1'b0, 5'b00100, 1'b0);
    check_val("mid_clear18", {59'd0, clears()}, 64'h04);
    next_cycle();
    drive(1'b1, 5'b00001, 1'b1);
    check_val("mid_send19", {63'd0, port_if.send_output}, 64'd1);
    check_val("mid_data19", port_if.data_out, 64'h3333_3333_3333_3333);
    #1;
    reset = 1'b1;
    #1;
    check_val("mid_rst_send", {63'd0, port_if.send_output}, 64'd0);
    check_val("mid_rst_data", port_if.data_out, 64'd0);
    check_val("mid_rst_empty", {63'd0, port_if.empty}, 64'd1);
    check_val("mid_rst_clear", {59'd0, clears()}, 64'd0);
    next_cycle();
    reset = 1'b0;
    drive(1'b1, 5'b00000, 1'b1);
    check_val("post_send_a", {63'd0, port_if.send_output}, 64'd0);
    check_val("post_empty_a", {63'd0, port_if.empty}, 64'd1);
    next_cycle();
    drive(1'b0, 5'b00000, 1'b1);
    check_val("post_send_b", {63'd0, port_if.send_output}, 64'd0);
    check_val("post_empty_b", {63'd0, port_if.empty}, 64'd1);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
